riscv_lsu: RTL and testbench

- Load/store unit for the non-pipelined core; sits directly downstream of the EX-stage ALU.
- Takes the ALU result as the effective address and rs2 as store data.
- Runs one data-memory transaction using a req/ready handshake, then returns sign- or zero-extended load data to writeback.
- Detects misaligned and illegal-width accesses without touching memory.

---
 rtl/riscv_lsu.sv | 185 ++++++++++++++++++
 tb/tb_riscv_lsu.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// Load/store unit: one req/ready data-memory transaction per start, with lane
// steering, load extension and fault detection. Define LSU_TIMEOUT_EN to bound the REQ wait.
module riscv_lsu #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata_in,
    output logic            busy,
    output logic            done,
    output logic [1:0]      fault,
    output logic [XLEN-1:0] load_data,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata
);

    if (XLEN != 32 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("riscv_lsu: XLEN must be 32 and TIMEOUT_CYCLES at least 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t          state_reg;
    logic            is_store_reg;
    logic [2:0]      funct3_reg;
    logic [1:0]      addr_lo_reg;

    logic            width_illegal;
    logic            misaligned;
    logic [1:0]      start_fault;
    logic [XLEN-1:0] lane_wdata;
    logic [3:0]      lane_wstrb;
    logic [XLEN-1:0] rdata_shifted;
    logic [XLEN-1:0] load_ext;
    logic            timeout_hit;

    // Decode of the request as presented with start.
    always_comb begin
        width_illegal = 1'b1;
        case (funct3)
            3'b000, 3'b001, 3'b010: width_illegal = 1'b0;
            3'b100, 3'b101:         width_illegal = is_store;
            default:                width_illegal = 1'b1;
        endcase
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        if (width_illegal)
            start_fault = 2'b10;
        else if (misaligned)
            start_fault = 2'b01;
        else
            start_fault = 2'b00;
    end

    always_comb begin
        lane_wdata = wdata_in;
        lane_wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                lane_wdata = {4{wdata_in[7:0]}};
                lane_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{wdata_in[15:0]}};
                lane_wstrb = 4'b0011 << addr[1:0];
            end
            default: begin
                lane_wdata = wdata_in;
                lane_wstrb = 4'b1111;
            end
        endcase
        if (!is_store)
            lane_wstrb = 4'b0000;
    end

    // Bring the addressed byte/halfword down to bit 0, then extend.
    always_comb begin
        rdata_shifted = mem_rdata >> {addr_lo_reg, 3'b000};
        case (funct3_reg)
            3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_ext = {24'd0, rdata_shifted[7:0]};
            3'b101:  load_ext = {16'd0, rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] timeout_cnt_reg;

    // Hit when this edge's increment would bring the count to TIMEOUT_CYCLES.
    assign timeout_hit = (state_reg == REQ) && !mem_ready &&
                         (timeout_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timeout_cnt_reg <= '0;
        else if (state_reg != REQ)
            timeout_cnt_reg <= '0;
        else if (!mem_ready)
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            is_store_reg <= 1'b0;
            funct3_reg   <= 3'b000;
            addr_lo_reg  <= 2'b00;
            busy         <= 1'b0;
            done         <= 1'b0;
            fault        <= 2'b00;
            load_data    <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= 4'b0000;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        is_store_reg <= is_store;
                        funct3_reg   <= funct3;
                        addr_lo_reg  <= addr[1:0];
                        mem_addr     <= {addr[XLEN-1:2], 2'b00};
                        mem_wdata    <= lane_wdata;
                        mem_wstrb    <= lane_wstrb;
                        busy         <= 1'b1;
                        if (start_fault != 2'b00) begin
                            fault     <= start_fault;
                            load_data <= '0;
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            state_reg <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        done      <= 1'b1;
                        fault     <= 2'b00;
                        load_data <= is_store_reg ? '0 : load_ext;
                        state_reg <= DONE;
                    end else if (timeout_hit) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        done      <= 1'b1;
                        fault     <= 2'b11;
                        load_data <= '0;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: per-feature tasks, expected results queued
// when a transaction is driven and compared when done appears.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata_in;
    logic        busy;
    logic        done;
    logic [1:0]  fault;
    logic [31:0] load_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          dly;
        logic [1:0]  flt;
        logic [31:0] ld;
        bit          req;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic [3:0]  strb;
        int          lat;
    } txn_t;

    typedef struct packed {
        int          lat;
        logic [1:0]  fault;
        logic [31:0] ld;
        logic [31:0] maddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
        logic        req_seen;
        logic        req_in_done;
    } obs_t;

    txn_t sb[$];

    riscv_lsu #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata_in  (wdata_in),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .load_data (load_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic txn_t mk(bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] rd, int dly, logic [1:0] flt, logic [31:0] ld,
                                bit req, logic [31:0] maddr, logic [31:0] mwd,
                                logic [3:0] strb, int lat);
        txn_t t;
        t.st = st; t.f3 = f3; t.a = a; t.wd = wd; t.rd = rd; t.dly = dly;
        t.flt = flt; t.ld = ld; t.req = req; t.maddr = maddr; t.mwd = mwd;
        t.strb = strb; t.lat = lat;
        return t;
    endfunction

    // Drives one start pulse and plays memory; lat = -1 means done never came.
    task automatic drive_txn(input txn_t t, input bit mid_start, output obs_t o);
        int  k;
        bit  got;
        o = '0;
        o.lat = -1;
        @(negedge clk);
        start = 1'b1; is_store = t.st; funct3 = t.f3; addr = t.a;
        wdata_in = t.wd; mem_rdata = t.rd; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; addr = $urandom; wdata_in = $urandom;
        k = 0;
        got = 1'b0;
        for (int c = 1; c <= 100 && !got; c++) begin
            if (done) begin
                got = 1'b1;
                o.lat = c; o.fault = fault; o.ld = load_data; o.req_in_done = mem_req;
            end else begin
                if (mem_req) begin
                    k++;
                    if (!o.req_seen) begin
                        o.maddr = mem_addr; o.wdata = mem_wdata;
                        o.wstrb = mem_wstrb; o.we = mem_we;
                    end
                    o.req_seen = 1'b1;
                    mem_ready = (k > t.dly);
                    if (mid_start && k == 2) begin
                        start = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h0000_0300;
                    end
                end
                @(negedge clk);
                start = 1'b0;
            end
        end
        mem_ready = 1'b0;
        start = 1'b0;
        $display("txn st=%0b f3=%03b addr=%h -> lat=%0d fault=%02b load_data=%h",
                 t.st, t.f3, t.a, o.lat, o.fault, o.ld);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({busy, done, mem_req, mem_we} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_ctrl got busy/done/req/we=%b want 0000", {busy, done, mem_req, mem_we}); end
        n_cmp++; if (fault !== 2'b00) begin n_fail++;
            $display("FAIL reset_fault got %b want 00", fault); end
        n_cmp++; if (load_data !== 32'h0) begin n_fail++;
            $display("FAIL reset_load_data got %h want 00000000", load_data); end
        n_cmp++; if ({mem_addr, mem_wdata} !== 64'h0) begin n_fail++;
            $display("FAIL reset_mem_bus got addr=%h wdata=%h want 0", mem_addr, mem_wdata); end
        n_cmp++; if (mem_wstrb !== 4'b0000) begin n_fail++;
            $display("FAIL reset_wstrb got %b want 0000", mem_wstrb); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_loads;
        txn_t tab[$];
        txn_t e;
        obs_t o;
        tab.push_back(mk(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 2'b00, 32'hDEADBEEF, 1, 32'h100, 0, 4'b0000, 2));
        tab.push_back(mk(0, 3'b000, 32'h103, 0, 32'h80112233, 0, 2'b00, 32'hFFFFFF80, 1, 32'h100, 0, 4'b0000, 2));
        tab.push_back(mk(0, 3'b100, 32'h103, 0, 32'h80112233, 0, 2'b00, 32'h00000080, 1, 32'h100, 0, 4'b0000, 2));
        tab.push_back(mk(0, 3'b101, 32'h102, 0, 32'h80112233, 1, 2'b00, 32'h00008011, 1, 32'h100, 0, 4'b0000, 3));
        tab.push_back(mk(0, 3'b001, 32'h102, 0, 32'h80112233, 0, 2'b00, 32'hFFFF8011, 1, 32'h100, 0, 4'b0000, 2));
        tab.push_back(mk(0, 3'b000, 32'h100, 0, 32'h80112233, 0, 2'b00, 32'h00000033, 1, 32'h100, 0, 4'b0000, 2));
        tab.push_back(mk(0, 3'b001, 32'h100, 0, 32'h80112233, 2, 2'b00, 32'h00002233, 1, 32'h100, 0, 4'b0000, 4));
        tab.push_back(mk(0, 3'b000, 32'h101, 0, 32'h80112233, 0, 2'b00, 32'h00000022, 1, 32'h100, 0, 4'b0000, 2));
        tab.push_back(mk(0, 3'b100, 32'h10E, 0, 32'h00F00000, 0, 2'b00, 32'h000000F0, 1, 32'h10C, 0, 4'b0000, 2));
        tab.push_back(mk(0, 3'b000, 32'h10E, 0, 32'h00F00000, 0, 2'b00, 32'hFFFFFFF0, 1, 32'h10C, 0, 4'b0000, 2));
        foreach (tab[i]) begin
            sb.push_back(tab[i]);
            drive_txn(tab[i], 1'b0, o);
            e = sb.pop_front();
            n_cmp++; if (o.lat != e.lat) begin n_fail++;
                $display("FAIL load[%0d] latency got %0d want %0d", i, o.lat, e.lat); end
            n_cmp++; if (o.fault !== e.flt) begin n_fail++;
                $display("FAIL load[%0d] fault got %b want %b", i, o.fault, e.flt); end
            n_cmp++; if (o.ld !== e.ld) begin n_fail++;
                $display("FAIL load[%0d] load_data got %h want %h", i, o.ld, e.ld); end
            n_cmp++; if ({o.req_seen, o.we, o.maddr, o.wstrb, o.req_in_done} !== {1'b1, 1'b0, e.maddr, 4'b0000, 1'b0}) begin
                n_fail++;
                $display("FAIL load[%0d] mem_req/we/addr/wstrb/req_in_done got %b/%b/%h/%b/%b want 1/0/%h/0000/0",
                         i, o.req_seen, o.we, o.maddr, o.wstrb, o.req_in_done, e.maddr);
            end
        end
    endtask

    task automatic test_hold;
        logic [31:0] last;
        last = load_data;
        repeat (3) @(negedge clk);
        n_cmp++; if (load_data !== 32'hFFFFFFF0 || last !== 32'hFFFFFFF0) begin n_fail++;
            $display("FAIL hold_load_data got %h (at done %h) want fffffff0", load_data, last); end
        n_cmp++; if ({busy, done, mem_req} !== 3'b000) begin n_fail++;
            $display("FAIL idle_outputs got busy/done/req=%b want 000", {busy, done, mem_req}); end
    endtask

    task automatic test_stores;
        txn_t tab[$];
        txn_t e;
        obs_t o;
        tab.push_back(mk(1, 3'b000, 32'h201, 32'h000000A5, 32'hFFFFFFFF, 0, 2'b00, 0, 1, 32'h200, 32'hA5A5A5A5, 4'b0010, 2));
        tab.push_back(mk(1, 3'b001, 32'h202, 32'h00001234, 32'hFFFFFFFF, 0, 2'b00, 0, 1, 32'h200, 32'h12341234, 4'b1100, 2));
        tab.push_back(mk(1, 3'b010, 32'h204, 32'hCAFEF00D, 32'hFFFFFFFF, 1, 2'b00, 0, 1, 32'h204, 32'hCAFEF00D, 4'b1111, 3));
        tab.push_back(mk(1, 3'b000, 32'h300, 32'hFFFFFF7E, 32'hFFFFFFFF, 0, 2'b00, 0, 1, 32'h300, 32'h7E7E7E7E, 4'b0001, 2));
        tab.push_back(mk(1, 3'b000, 32'h303, 32'h0000003C, 32'hFFFFFFFF, 3, 2'b00, 0, 1, 32'h300, 32'h3C3C3C3C, 4'b1000, 5));
        tab.push_back(mk(1, 3'b001, 32'h304, 32'hBEEF5678, 32'hFFFFFFFF, 0, 2'b00, 0, 1, 32'h304, 32'h56785678, 4'b0011, 2));
        foreach (tab[i]) begin
            sb.push_back(tab[i]);
            drive_txn(tab[i], 1'b0, o);
            e = sb.pop_front();
            n_cmp++; if (o.lat != e.lat) begin n_fail++;
                $display("FAIL store[%0d] latency got %0d want %0d", i, o.lat, e.lat); end
            n_cmp++; if ({o.fault, o.ld} !== {e.flt, e.ld}) begin n_fail++;
                $display("FAIL store[%0d] fault/load_data got %b/%h want %b/%h", i, o.fault, o.ld, e.flt, e.ld); end
            n_cmp++; if ({o.req_seen, o.we, o.req_in_done} !== 3'b110) begin n_fail++;
                $display("FAIL store[%0d] req/we/req_in_done got %b%b%b want 110", i, o.req_seen, o.we, o.req_in_done); end
            n_cmp++; if (o.maddr !== e.maddr) begin n_fail++;
                $display("FAIL store[%0d] mem_addr got %h want %h", i, o.maddr, e.maddr); end
            n_cmp++; if (o.wdata !== e.mwd) begin n_fail++;
                $display("FAIL store[%0d] mem_wdata got %h want %h", i, o.wdata, e.mwd); end
            n_cmp++; if (o.wstrb !== e.strb) begin n_fail++;
                $display("FAIL store[%0d] mem_wstrb got %b want %b", i, o.wstrb, e.strb); end
        end
    endtask

    task automatic test_faults;
        txn_t tab[$];
        txn_t e;
        obs_t o;
        tab.push_back(mk(0, 3'b010, 32'h102, 0, 32'h12345678, 0, 2'b01, 0, 0, 0, 0, 0, 1));
        tab.push_back(mk(1, 3'b100, 32'h200, 32'h11, 32'h12345678, 0, 2'b10, 0, 0, 0, 0, 0, 1));
        tab.push_back(mk(0, 3'b001, 32'h101, 0, 32'h12345678, 0, 2'b01, 0, 0, 0, 0, 0, 1));
        tab.push_back(mk(0, 3'b011, 32'h101, 0, 32'h12345678, 0, 2'b10, 0, 0, 0, 0, 0, 1));
        tab.push_back(mk(1, 3'b010, 32'h203, 32'h22, 32'h12345678, 0, 2'b01, 0, 0, 0, 0, 0, 1));
        tab.push_back(mk(0, 3'b101, 32'h103, 0, 32'h12345678, 0, 2'b01, 0, 0, 0, 0, 0, 1));
        tab.push_back(mk(1, 3'b101, 32'h200, 32'h33, 32'h12345678, 0, 2'b10, 0, 0, 0, 0, 0, 1));
        tab.push_back(mk(0, 3'b110, 32'h100, 0, 32'h12345678, 0, 2'b10, 0, 0, 0, 0, 0, 1));
        foreach (tab[i]) begin
            sb.push_back(tab[i]);
            drive_txn(tab[i], 1'b0, o);
            e = sb.pop_front();
            n_cmp++; if (o.lat != e.lat) begin n_fail++;
                $display("FAIL fault[%0d] latency got %0d want %0d", i, o.lat, e.lat); end
            n_cmp++; if (o.fault !== e.flt) begin n_fail++;
                $display("FAIL fault[%0d] fault got %b want %b", i, o.fault, e.flt); end
            n_cmp++; if (o.ld !== e.ld) begin n_fail++;
                $display("FAIL fault[%0d] load_data got %h want %h", i, o.ld, e.ld); end
            n_cmp++; if ({o.req_seen, o.req_in_done} !== 2'b00) begin n_fail++;
                $display("FAIL fault[%0d] mem_req seen got %b%b want 00", i, o.req_seen, o.req_in_done); end
        end
    endtask

    task automatic test_back_to_back;
        txn_t t0, t1, e;
        obs_t o;
        bit   stray;
        t0 = mk(0, 3'b010, 32'h108, 0, 32'h01020304, 5, 2'b00, 32'h01020304, 1, 32'h108, 0, 4'b0000, 7);
        t1 = mk(0, 3'b100, 32'h10A, 0, 32'h55AA0000, 0, 2'b00, 32'h000000AA, 1, 32'h108, 0, 4'b0000, 2);
        sb.push_back(t0);
        drive_txn(t0, 1'b1, o);
        e = sb.pop_front();
        n_cmp++; if (o.lat != e.lat) begin n_fail++;
            $display("FAIL b2b_wait latency got %0d want %0d", o.lat, e.lat); end
        n_cmp++; if ({o.fault, o.ld, o.we} !== {e.flt, e.ld, 1'b0}) begin n_fail++;
            $display("FAIL b2b_wait fault/load_data/we got %b/%h/%b want %b/%h/0", o.fault, o.ld, o.we, e.flt, e.ld); end
        stray = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || mem_req) stray = 1'b1;
        end
        n_cmp++; if (stray !== 1'b0) begin n_fail++;
            $display("FAIL b2b_ignored_start got extra activity=%b want 0", stray); end
        sb.push_back(t1);
        drive_txn(t1, 1'b0, o);
        e = sb.pop_front();
        n_cmp++; if ({o.lat, o.ld, o.maddr} !== {e.lat, e.ld, e.maddr}) begin n_fail++;
            $display("FAIL b2b_next lat/load_data/addr got %0d/%h/%h want %0d/%h/%h",
                     o.lat, o.ld, o.maddr, e.lat, e.ld, e.maddr); end
    endtask

    task automatic test_reset_mid;
        bit stray;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h400; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_fail++;
            $display("FAIL rst_mid_req_before got %b want 1", mem_req); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({mem_req, busy, done} !== 3'b000) begin n_fail++;
            $display("FAIL rst_mid_async got req/busy/done=%b want 000", {mem_req, busy, done}); end
        @(negedge clk);
        rst = 1'b0;
        stray = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || mem_req) stray = 1'b1;
        end
        $display("txn reset mid-REQ -> stray activity=%0b", stray);
        n_cmp++; if (stray !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_no_done got activity=%b want 0", stray); end
    endtask

    task automatic test_timeout;
        txn_t t;
        txn_t e;
        obs_t o;
        // Ready arrives on the 16th REQ cycle: completes normally in both builds.
        t = mk(0, 3'b010, 32'h500, 0, 32'h11111111, 15, 2'b00, 32'h11111111, 1, 32'h500, 0, 4'b0000, 17);
        sb.push_back(t);
        drive_txn(t, 1'b0, o);
        e = sb.pop_front();
        n_cmp++; if ({o.lat, o.fault, o.ld} !== {e.lat, e.flt, e.ld}) begin n_fail++;
            $display("FAIL ready_at_limit lat/fault/load_data got %0d/%b/%h want %0d/%b/%h",
                     o.lat, o.fault, o.ld, e.lat, e.flt, e.ld); end
`ifdef LSU_TIMEOUT_EN
        t = mk(0, 3'b010, 32'h504, 0, 32'h22222222, 1000, 2'b11, 32'h0, 1, 32'h504, 0, 4'b0000, 17);
`else
        t = mk(0, 3'b010, 32'h504, 0, 32'h22222222, 20, 2'b00, 32'h22222222, 1, 32'h504, 0, 4'b0000, 22);
`endif
        sb.push_back(t);
        drive_txn(t, 1'b0, o);
        e = sb.pop_front();
        n_cmp++; if ({o.lat, o.fault, o.ld, o.req_in_done} !== {e.lat, e.flt, e.ld, 1'b0}) begin n_fail++;
            $display("FAIL long_wait lat/fault/load_data/req got %0d/%b/%h/%b want %0d/%b/%h/0",
                     o.lat, o.fault, o.ld, o.req_in_done, e.lat, e.flt, e.ld); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata_in = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_loads();
        test_hold();
        test_stores();
        test_faults();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
